top_req_gen: RTL and testbench

Initiator for the `data`/`en`/`addr` interface: accepts WIDTH-bit command words over a valid/ready port and drives each word onto `data` with a one-cycle `en` strobe. It samples the 32-bit `addr` returned by the consumer a fixed RSP_LAT cycles later and buffers the results in a DEPTH-entry response FIFO. It sits between a command source and any block exposing the `data`/`en` input and `addr` output ports.

---
 rtl/top_req_gen_pkg.sv | 11 +
 rtl/top_req_gen_if.sv | 32 +++
 rtl/top_req_gen_fifo.sv | 67 ++++++
 rtl/top_req_gen.sv | 102 ++++++++++
 tb/tb_top_req_gen.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/top_req_gen_pkg.sv
// Shared types and constants for the request generator slice.
package top_if_pkg;
  localparam int ADDR_W      = 32;
  localparam int DEF_WIDTH   = 8;
  localparam int RSP_LAT_MAX = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;
endpackage

// File: rtl/top_req_gen_if.sv
// Command, consumer and response signals of the request generator.
interface top_req_gen_if
  import top_if_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int DEPTH = WIDTH + 2;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [WIDTH-1:0]  cmd_data;
  logic              flush;
  logic [WIDTH-1:0]  data;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ADDR_W-1:0] rsp_addr;
  logic [LVL_W-1:0]  level;
  logic              busy;

  modport master (
    input  cmd_valid, cmd_data, flush, addr, rsp_ready,
    output cmd_ready, data, en, rsp_valid, rsp_addr, level, busy
  );

  modport slave (
    output cmd_valid, cmd_data, flush, addr, rsp_ready,
    input  cmd_ready, data, en, rsp_valid, rsp_addr, level, busy
  );
endinterface

// File: rtl/top_req_gen_fifo.sv
// First-word-fall-through response FIFO with synchronous clear; handles any
// depth, not only powers of two.
module addr_rsp_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 10,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          clear,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [LW-1:0] level
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Qualify push/pop against current occupancy.
  always_comb begin
    pop_ok_s  = pop && (level_r != {LW{1'b0}});
    push_ok_s = push && ((level_r != LW'(DEPTH)) || pop_ok_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= nxt(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= nxt(rd_ptr_r);
      end
      level_r <= level_r + LW'(push_ok_s) - LW'(pop_ok_s);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = (level_r != {LW{1'b0}});
  assign level = level_r;
endmodule

// File: rtl/top_req_gen.sv
// Request generator: issues command words with an en strobe, captures the
// consumer's addr a fixed latency later and queues it for the response port.
module top_req_gen
  import top_if_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int RSP_LAT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  top_req_gen_if.master   bus
);
  localparam int DEPTH = WIDTH + 2;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int OW    = $clog2(RSP_LAT_MAX + 2);
  localparam int SW    = ((LW > OW) ? LW : OW) + 1;

  state_e             state_r;
  logic [WIDTH-1:0]   data_r;
  logic               en_r;
  logic [RSP_LAT-1:0] vld_r;
  logic [OW-1:0]      outstanding_s;
  logic [SW-1:0]      sum_s;
  logic               cmd_ready_s;
  logic               fire_s;
  logic               clear_s;
  logic               rsp_valid_s;
  logic               pop_s;
  logic               busy_s;
  logic               fifo_valid_s;
  logic [LW-1:0]      level_s;
  logic [ADDR_W-1:0]  head_s;

  // Responses in flight: the live strobe plus every set pipeline stage.
  always_comb begin
    outstanding_s = {{(OW-1){1'b0}}, en_r};
    for (int i = 0; i < RSP_LAT; i++) begin
      outstanding_s = outstanding_s + {{(OW-1){1'b0}}, vld_r[i]};
    end
  end

  // Credit and handshake qualification, derived from registered state only.
  always_comb begin
    sum_s = SW'(level_s) + SW'(outstanding_s);
    if ((state_r == RUN) && (sum_s < SW'(DEPTH))) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
    fire_s      = bus.cmd_valid && cmd_ready_s;
    rsp_valid_s = (state_r == RUN) && fifo_valid_s;
    pop_s       = bus.rsp_ready && rsp_valid_s;
    clear_s     = (state_r == FLUSH) && (outstanding_s == {OW{1'b0}});
    busy_s      = (outstanding_s != {OW{1'b0}}) || (state_r == FLUSH);
  end

  // Issue register, in-flight pipeline and RUN/FLUSH control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      data_r  <= {WIDTH{1'b0}};
      en_r    <= 1'b0;
      vld_r   <= {RSP_LAT{1'b0}};
    end else begin
      en_r <= fire_s;
      if (fire_s) begin
        data_r <= bus.cmd_data;
      end
      vld_r[0] <= en_r;
      for (int i = 1; i < RSP_LAT; i++) vld_r[i] <= vld_r[i-1];
      case (state_r)
        RUN:     state_r <= bus.flush ? FLUSH : RUN;
        FLUSH:   state_r <= clear_s ? RUN : FLUSH;
        default: state_r <= RUN;
      endcase
    end
  end

  addr_rsp_fifo #(
    .DW    (ADDR_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_r[RSP_LAT-1]),
    .din   (bus.addr),
    .pop   (pop_s),
    .clear (clear_s),
    .dout  (head_s),
    .valid (fifo_valid_s),
    .level (level_s)
  );

  assign bus.cmd_ready = cmd_ready_s;
  assign bus.data      = data_r;
  assign bus.en        = en_r;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_addr  = head_s;
  assign bus.level     = level_s;
  assign bus.busy      = busy_s;
endmodule

// File: tb/tb_top_req_gen.sv
// Directed bench for top_req_gen: per-cycle vector table plus hand-written
// streaming, backpressure, flush, push/pop and async-reset sequences.
module tb_top_req_gen;
  localparam int W   = 8;
  localparam int LAT = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   en_cnt;
  int   run;
  int   max_run;
  int   pops;
  int   crdy_drop;
  logic [7:0]  iss_q [$];
  logic [31:0] exp_q [$];
  logic [7:0]  pd [LAT];
  logic        pv [LAT];

  top_req_gen_if #(.WIDTH(W)) bus ();

  top_req_gen #(.WIDTH(W), .RSP_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer model: addr answers RSP_LAT cycles after each en.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pd[i] <= 8'h00;
        pv[i] <= 1'b0;
      end
    end else begin
      pd[0] <= bus.data;
      pv[0] <= bus.en;
      for (int i = 1; i < LAT; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1];
      end
    end
  end
  assign bus.addr = pv[LAT-1] ? (32'h1000_0000 | {24'h000000, pd[LAT-1]}) : 32'hDEAD_BEEF;

  typedef struct {
    logic        cv;
    logic [7:0]  cd;
    logic        rr;
    logic        fl;
    logic        e_en;
    logic [7:0]  e_data;
    logic        e_rv;
    logic [31:0] e_ra;
    logic        chk_ra;
    logic [3:0]  e_lvl;
    logic        e_busy;
    logic        e_crdy;
  } vec_t;
  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // One clock: scoreboard bookkeeping for this cycle, then advance.
  task automatic tick();
    logic [7:0] d;
    if (bus.cmd_valid && bus.cmd_ready) iss_q.push_back(bus.cmd_data);
    if (bus.rsp_valid && bus.rsp_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("rsp_unexpected", bus.rsp_addr, 32'hFFFF_FFFF);
      else chk("rsp_order", bus.rsp_addr, exp_q.pop_front());
    end
    if (bus.en) begin
      en_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (iss_q.size() == 0) begin
        chk("en_unexpected", {24'h0, bus.data}, 32'hFFFF_FFFF);
      end else begin
        d = iss_q.pop_front();
        chk("en_data", {24'h0, bus.data}, {24'h0, d});
        exp_q.push_back(32'h1000_0000 | {24'h0, d});
      end
    end else begin
      run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < budget; k++) begin
      if (bus.level == 4'd0 && !bus.busy) break;
      tick();
    end
    bus.rsp_ready = 1'b0;
    chk("drain_level", {28'h0, bus.level}, 32'd0);
    chk("drain_sb_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0; n_fail = 0; en_cnt = 0; run = 0; max_run = 0; pops = 0; crdy_drop = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.flush = 1'b0; bus.rsp_ready = 1'b0;

    vt[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 1'b1, 4'd0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b1};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b1};
    vt[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b1};
    vt[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 32'h1000_00A5, 1'b1, 4'd1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 32'h1000_00A5, 1'b1, 4'd1, 1'b0, 1'b1};
    vt[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 32'h0000_0000, 1'b0, 4'd0, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state and single command, cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid = vt[i].cv;
      bus.cmd_data  = vt[i].cd;
      bus.rsp_ready = vt[i].rr;
      bus.flush     = vt[i].fl;
      chk($sformatf("v%0d_en", i), {31'h0, bus.en}, {31'h0, vt[i].e_en});
      chk($sformatf("v%0d_data", i), {24'h0, bus.data}, {24'h0, vt[i].e_data});
      chk($sformatf("v%0d_rsp_valid", i), {31'h0, bus.rsp_valid}, {31'h0, vt[i].e_rv});
      if (vt[i].chk_ra) chk($sformatf("v%0d_rsp_addr", i), bus.rsp_addr, vt[i].e_ra);
      chk($sformatf("v%0d_level", i), {28'h0, bus.level}, {28'h0, vt[i].e_lvl});
      chk($sformatf("v%0d_busy", i), {31'h0, bus.busy}, {31'h0, vt[i].e_busy});
      chk($sformatf("v%0d_cmd_ready", i), {31'h0, bus.cmd_ready}, {31'h0, vt[i].e_crdy});
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;

    // Streaming: 20 back-to-back commands with rsp_ready held high.
    max_run = 0; run = 0; pops = 0; crdy_drop = 0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h20 + 8'(i);
      if (!bus.cmd_ready) crdy_drop++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (LAT + 4) tick();
    chk("stream_en_run", max_run, 32'd20);
    chk("stream_pops", pops, 32'd20);
    chk("stream_crdy_drops", crdy_drop, 32'd0);
    chk("stream_sb_empty", exp_q.size(), 32'd0);
    bus.rsp_ready = 1'b0;

    // Backpressure: credit caps issues at DEPTH.
    en_cnt = 0;
    for (int i = 0; i < 18; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h40 + 8'(i);
      tick();
    end
    chk("bp_en_count", en_cnt, 32'd10);
    chk("bp_level", {28'h0, bus.level}, 32'd10);
    chk("bp_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    en_cnt = 0;
    chk("bp_ready_after_pop", {31'h0, bus.cmd_ready}, 32'd1);
    repeat (6) tick();
    bus.cmd_valid = 1'b0;
    chk("bp_one_more_issue", en_cnt, 32'd1);
    chk("bp_level_refill", {28'h0, bus.level}, 32'd10);
    drain(40);

    // Flush with 4 buffered and 2 in flight.
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h60 + 8'(i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.level == 4'd4 && !bus.busy) break;
      tick();
    end
    chk("fl_pre_level", {28'h0, bus.level}, 32'd4);
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h70; tick();
    bus.cmd_data = 8'h71; tick();
    bus.cmd_valid = 1'b0;
    bus.flush = 1'b1;
    chk("fl_pre_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
    tick();
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    pops = 0;
    chk("fl_cmd_ready", {31'h0, bus.cmd_ready}, 32'd0);
    chk("fl_busy", {31'h0, bus.busy}, 32'd1);
    begin
      int k;
      for (k = 0; k < 8; k++) begin
        if (bus.level == 4'd0 && !bus.busy) break;
        chk("fl_rsp_valid_low", {31'h0, bus.rsp_valid}, 32'd0);
        tick();
      end
      n_tests++;
      if (k > LAT + 1) begin
        n_fail++;
        $display("FAIL fl_latency: took %0d cycles, limit %0d", k, LAT + 1);
      end
    end
    chk("fl_level", {28'h0, bus.level}, 32'd0);
    chk("fl_busy_done", {31'h0, bus.busy}, 32'd0);
    chk("fl_run_ready", {31'h0, bus.cmd_ready}, 32'd1);
    repeat (2) tick();
    chk("fl_no_stale_pop", pops, 32'd0);
    bus.rsp_ready = 1'b0;
    exp_q.delete();
    iss_q.delete();

    // Simultaneous push and pop at level 5.
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h80 + 8'(i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (bus.level == 4'd5 && !bus.busy) break;
      tick();
    end
    chk("pp_pre_level", {28'h0, bus.level}, 32'd5);
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h85; tick();
    bus.cmd_valid = 1'b0;
    repeat (LAT) tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("pp_level", {28'h0, bus.level}, 32'd5);
    pops = 0;
    drain(20);
    chk("pp_drain_pops", pops, 32'd5);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_data  = 8'h90 + 8'(i);
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("rst_pre_en", {31'h0, bus.en}, 32'd1);
    chk("rst_pre_level", {28'h0, bus.level}, 32'd4);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_en", {31'h0, bus.en}, 32'd0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
    chk("rst_level", {28'h0, bus.level}, 32'd0);
    chk("rst_busy", {31'h0, bus.busy}, 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    iss_q.delete();
    chk("post_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_data = 8'h77; tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (bus.rsp_valid) break;
      tick();
    end
    chk("post_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'd1);
    chk("post_rst_rsp_addr", bus.rsp_addr, 32'h1000_0077);
    tick();
    bus.rsp_ready = 1'b0;
    chk("post_rst_level", {28'h0, bus.level}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
